// File: rtl/jt900h_memctl.sv
// jt900h_memctl: memory-side stage below the jt900h RAM port.
// Turns the core's zero-wait port into a stalled access on either a
// fixed-wait-state RAM or a handshaked ROM, gating the core clock enable
// until the requested word is valid.
//
// Handshake: the core is frozen (cpu_cen low) on every cycle that is not a
// hit. A hit means the last completed access matches the current word
// address and byte enables. Only then does the core advance. The core's
// outputs are therefore stable for the whole backend access. rom_cs is a
// level request held until rom_ok or timeout. rom_ok is honoured only while
// the request is pending.
module jt900h_memctl #(
    parameter logic [23:0] ROM_BASE = 24'h200000,
    parameter int          RAM_WS   = 2,
    parameter int          TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen_in,
    output logic        cpu_cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_dout,
    output logic        ram_cs,
    output logic [22:0] ram_addr,
    output logic [15:0] ram_din,
    output logic [1:0]  ram_we,
    input  logic [15:0] ram_dout,
    output logic        rom_cs,
    output logic [22:0] rom_addr,
    input  logic        rom_ok,
    input  logic [15:0] rom_data,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMWS = 2'd1,
        ST_ROMWT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] WS_INIT = 8'(RAM_WS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [22:0] r_addr;
    logic [1:0]  r_we;
    logic [15:0] r_din;
    logic [22:0] r_last_addr;
    logic [1:0]  r_last_we;
    logic        r_valid;
    logic [7:0]  r_cnt;
    logic [15:0] r_dout;
    logic        r_bus_err;

    logic        w_hit;
    logic        w_rom_sel;

    // Hit and region decode from the live core request
    always_comb begin
        w_hit     = r_valid && (cpu_addr[23:1] == r_last_addr) && (cpu_we == r_last_we);
        w_rom_sel = (cpu_addr >= ROM_BASE);
    end

    // Backend strobes are pure decodes of the registered state
    always_comb begin
        cpu_cen  = cen_in && (r_state == ST_IDLE) && w_hit;
        ram_cs   = (r_state == ST_RAMWS);
        ram_addr = r_addr;
        ram_din  = r_din;
        ram_we   = (r_state == ST_RAMWS) ? r_we : 2'b00;
        rom_cs   = (r_state == ST_ROMWT);
        rom_addr = r_addr;
        cpu_dout = r_dout;
        bus_err  = r_bus_err;
    end

    // Access FSM: miss capture, RAM wait count, ROM wait/timeout, commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_we        <= '0;
            r_din       <= '0;
            r_last_addr <= '0;
            r_last_we   <= '0;
            r_valid     <= 1'b0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cen_in && !w_hit) begin
                        r_addr <= cpu_addr[23:1];
                        r_we   <= cpu_we;
                        r_din  <= cpu_din;
                        if (w_rom_sel) begin
                            if (cpu_we != 2'b00) begin
                                // ROM is read-only: flag and complete without access
                                r_bus_err <= 1'b1;
                                r_state   <= ST_DONE;
                            end else begin
                                r_cnt   <= '0;
                                r_state <= ST_ROMWT;
                            end
                        end else begin
                            r_cnt   <= WS_INIT;
                            r_state <= ST_RAMWS;
                        end
                    end
                end
                ST_RAMWS: begin
                    if (r_cnt == 8'd0) begin
                        if (r_we == 2'b00) begin
                            r_dout <= ram_dout;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_ROMWT: begin
                    // rom_ok has priority over the timeout on the same cycle
                    if (rom_ok) begin
                        r_dout  <= rom_data;
                        r_state <= ST_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_dout    <= 16'hFFFF;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_valid     <= 1'b1;
                    r_last_addr <= r_addr;
                    r_last_we   <= r_we;
                    r_cnt       <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
